// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
// Pure declarations; no logic, no latency, no flow control.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX_DEC = 4'd9;
    localparam bcd_t DIGIT_MAX_SEX = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with programmable top value and ripple carry out.
// Digit updates one cycle after inc; carry is combinational; no backpressure.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  bcd_t limit,
    output bcd_t digit,
    output logic carry
);

    assign carry = inc && (digit == limit);

    // clr outranks inc so a same-cycle clear never leaves a stray increment
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= carry ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS BCD stopwatch driven by a synchronized external tick, with run/pause/lap/clear.
// Tick to count: SYNC_STAGES+1 edges, disp one more; commands act in one cycle; no backpressure.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] disp,
    output logic        running,
    output logic        tick_seen,
    output logic        rollover
);

    localparam bcd_t MAX_TENS = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MAX_ONES = bcd_t'(MAX_MIN % 10);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] primed;
    logic                   prev;
    logic                   armed;
    state_t                 state;

    bcd_t sec_ones, sec_tens, min_ones, min_tens;
    logic c0, c1, c2, c3;
    logic counting, inc0, at_max, wrap, dclr;
    logic [15:0] live;

    // armed only after a real low has travelled the whole chain, so a level
    // already high when reset releases is not mistaken for a fresh edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync   <= '0;
            primed <= '0;
            prev   <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], tick_in};
            primed <= {primed[SYNC_STAGES-2:0], 1'b1};
            prev   <= sync[SYNC_STAGES-1];
            if (primed[SYNC_STAGES-1] && !sync[SYNC_STAGES-1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign tick_seen = armed && sync[SYNC_STAGES-1] && !prev;

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign inc0     = tick_seen && counting;
    assign at_max   = (min_tens == MAX_TENS) && (min_ones == MAX_ONES) &&
                      (sec_tens == DIGIT_MAX_SEX) && (sec_ones == DIGIT_MAX_DEC);
    // c3 only fires at 99:59, which is already the top when MAX_MIN is 99
    assign wrap     = !clear && ((inc0 && at_max) || c3);
    assign dclr     = clear || wrap;
    assign live     = {min_tens, min_ones, sec_tens, sec_ones};

    bcd_digit u_sec_ones (.clk(clk), .rst(rst), .clr(dclr), .inc(inc0),
                          .limit(DIGIT_MAX_DEC), .digit(sec_ones), .carry(c0));
    bcd_digit u_sec_tens (.clk(clk), .rst(rst), .clr(dclr), .inc(c0),
                          .limit(DIGIT_MAX_SEX), .digit(sec_tens), .carry(c1));
    bcd_digit u_min_ones (.clk(clk), .rst(rst), .clr(dclr), .inc(c1),
                          .limit(DIGIT_MAX_DEC), .digit(min_ones), .carry(c2));
    bcd_digit u_min_tens (.clk(clk), .rst(rst), .clr(dclr), .inc(c2),
                          .limit(DIGIT_MAX_DEC), .digit(min_tens), .carry(c3));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            disp     <= '0;
            rollover <= 1'b0;
        end else begin
            rollover <= wrap;
            if (clear) begin
                state   <= ST_IDLE;
                running <= 1'b0;
                disp    <= '0;
            end else if (start_stop) begin
                if (counting) begin
                    state   <= ST_PAUSE;
                    running <= 1'b0;
                end else begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                end
                disp <= live;
            end else if (lap && state == ST_RUN) begin
                state <= ST_LAP;
                disp  <= live;
            end else if (lap && state == ST_LAP) begin
                state <= ST_RUN;
                disp  <= live;
            end else if (state != ST_LAP) begin
                disp <= live;
            end
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch; a second instance with MAX_MIN=1 exercises wrap.
module tb_bcd_stopwatch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_in = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] disp, disp1;
    logic        running, running1, tick_seen, tick_seen1, rollover, rollover1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ts_cnt = 0;
    int ts1_cnt = 0;
    int ts_last = -1;
    int ts_prev = -1;
    int ro_cnt = 0;
    int ro1_cnt = 0;

    bcd_stopwatch dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .disp(disp), .running(running),
        .tick_seen(tick_seen), .rollover(rollover)
    );

    bcd_stopwatch #(.SYNC_STAGES(2), .MAX_MIN(1)) dut1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .disp(disp1), .running(running1),
        .tick_seen(tick_seen1), .rollover(rollover1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tick_seen) begin
            ts_cnt  <= ts_cnt + 1;
            ts_prev <= ts_last;
            ts_last <= cyc;
        end
        if (tick_seen1) ts1_cnt <= ts1_cnt + 1;
        if (rollover)   ro_cnt  <= ro_cnt + 1;
        if (rollover1)  ro1_cnt <= ro1_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(4);
    endtask

    task automatic pulse(input logic s, input logic c, input logic l);
        start_stop = s;
        clear      = c;
        lap        = l;
        step(1);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_in = 1'b1;
            step(3);
            tick_in = 1'b0;
            step(3);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(2);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h exp 0000", disp); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
        checks++; if (tick_seen !== 1'b0) begin errors++; $display("FAIL reset_tick_seen got %b exp 0", tick_seen); end
        checks++; if (rollover !== 1'b0) begin errors++; $display("FAIL reset_rollover got %b exp 0", rollover); end
        checks++; if (disp1 !== 16'h0000 || running1 !== 1'b0) begin errors++; $display("FAIL reset_dut1 got %h/%b exp 0000/0", disp1, running1); end
        rst = 1'b1;
        step(4);
    endtask

    task automatic test_count();
        int s;
        s = ts_cnt;
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL count_running got %b exp 1", running); end
        tick(12);
        checks++; if (disp !== 16'h0012) begin errors++; $display("FAIL count_disp got %h exp 0012", disp); end
        checks++; if (ts_cnt - s !== 12) begin errors++; $display("FAIL count_tick_seen got %0d exp 12", ts_cnt - s); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL count_running_end got %b exp 1", running); end
    endtask

    task automatic test_carry_wrap();
        int r0;
        do_reset();
        r0 = ro_cnt;
        pulse(1'b1, 1'b0, 1'b0);
        tick(59);
        checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL carry_pre got %h exp 0059", disp); end
        tick(1);
        checks++; if (disp !== 16'h0100) begin errors++; $display("FAIL carry_min got %h exp 0100", disp); end
        checks++; if (disp1 !== 16'h0100) begin errors++; $display("FAIL carry_min_dut1 got %h exp 0100", disp1); end
        tick(59);
        checks++; if (disp1 !== 16'h0159) begin errors++; $display("FAIL wrap_pre got %h exp 0159", disp1); end
        checks++; if (ro1_cnt !== 0) begin errors++; $display("FAIL wrap_early_rollover got %0d exp 0", ro1_cnt); end
        tick(1);
        checks++; if (disp1 !== 16'h0000) begin errors++; $display("FAIL wrap_disp got %h exp 0000", disp1); end
        checks++; if (ro1_cnt !== 1) begin errors++; $display("FAIL wrap_rollover_cycles got %0d exp 1", ro1_cnt); end
        checks++; if (disp !== 16'h0200 || ro_cnt !== r0) begin errors++; $display("FAIL wrap_default_dut got %h/%0d exp 0200/%0d", disp, ro_cnt, r0); end
        tick(1);
        checks++; if (disp1 !== 16'h0001) begin errors++; $display("FAIL wrap_continue got %h exp 0001", disp1); end
    endtask

    task automatic test_lap();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        tick(5);
        checks++; if (disp !== 16'h0005) begin errors++; $display("FAIL lap_pre got %h exp 0005", disp); end
        pulse(1'b0, 1'b0, 1'b1);
        tick(3);
        checks++; if (disp !== 16'h0005) begin errors++; $display("FAIL lap_hold got %h exp 0005", disp); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running got %b exp 1", running); end
        pulse(1'b0, 1'b0, 1'b1);
        checks++; if (disp !== 16'h0008) begin errors++; $display("FAIL lap_release got %h exp 0008", disp); end
        tick(1);
        checks++; if (disp !== 16'h0009) begin errors++; $display("FAIL lap_resume got %h exp 0009", disp); end
    endtask

    task automatic test_clear_priority();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        tick(30);
        checks++; if (disp !== 16'h0030) begin errors++; $display("FAIL clear_pre got %h exp 0030", disp); end
        tick_in = 1'b1;
        step(2);
        checks++; if (tick_seen !== 1'b1) begin errors++; $display("FAIL clear_tick_align got %b exp 1", tick_seen); end
        pulse(1'b1, 1'b1, 1'b1);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL clear_disp got %h exp 0000", disp); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_running got %b exp 0", running); end
        tick_in = 1'b0;
        step(3);
        tick(1);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL clear_idle_tick got %h exp 0000", disp); end
    endtask

    task automatic test_glitch();
        int s, c0;
        do_reset();
        s = ts_cnt;
        c0 = cyc;
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
        step(2);
        tick_in = 1'b1;
        step(3);
        tick_in = 1'b0;
        step(4);
        checks++; if (ts_cnt - s !== 2) begin errors++; $display("FAIL glitch_count got %0d exp 2", ts_cnt - s); end
        checks++; if (ts_prev !== c0 + 2) begin errors++; $display("FAIL glitch_latency got %0d exp %0d", ts_prev, c0 + 2); end
        checks++; if (ts_last !== c0 + 5) begin errors++; $display("FAIL glitch_spacing got %0d exp %0d", ts_last, c0 + 5); end
    endtask

    task automatic test_reset_midrun();
        int s;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        tick(42);
        checks++; if (disp !== 16'h0042) begin errors++; $display("FAIL midrun_pre got %h exp 0042", disp); end
        tick_in = 1'b1;
        step(4);
        rst = 1'b0;
        start_stop = 1'b1;
        step(1);
        rst = 1'b1;
        start_stop = 1'b0;
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL midrun_disp got %h exp 0000", disp); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrun_running got %b exp 0", running); end
        s = ts_cnt;
        step(8);
        checks++; if (ts_cnt !== s) begin errors++; $display("FAIL midrun_held_high got %0d exp %0d", ts_cnt, s); end
        tick_in = 1'b0;
        step(3);
        tick(1);
        checks++; if (ts_cnt !== s + 1) begin errors++; $display("FAIL midrun_new_edge got %0d exp %0d", ts_cnt, s + 1); end
        checks++; if (disp !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL midrun_idle got %h/%b exp 0000/0", disp, running); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry_wrap();
        test_lap();
        test_clear_priority();
        test_glitch();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
